// File: rtl/interconnect_pkg.sv
// Shared constants for the apb_bus_router message interconnect.
package interconnect_pkg;
    localparam int NUM_SINKS   = 8;
    localparam int NUM_SOURCES = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 6;
    localparam int BRDCST_ADDR = NUM_SOURCES;
    localparam int PTR_WIDTH   = $clog2(NUM_SINKS);
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic                                    pclk,
    input  logic                                    reset,
    input  logic [N-1:0]                            req,
    output logic                                    grant_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]    grant_idx
);
    import interconnect_pkg::*;

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin : p_search
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/apb_bus_router.sv
// N-master to M-slave message router: per-master holding registers, round-robin
// serialisation onto a shared slave bus, unicast plus subscribed broadcast.
module apb_bus_router #(
    parameter int NUM_SINKS   = interconnect_pkg::NUM_SINKS,
    parameter int NUM_SOURCES = interconnect_pkg::NUM_SOURCES,
    parameter int DATA_WIDTH  = interconnect_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = interconnect_pkg::ADDR_WIDTH
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  master_data [NUM_SINKS],
    input  logic [ADDR_WIDTH-1:0]  dest_addrs [NUM_SINKS],
    input  logic [NUM_SINKS-1:0]   master_valids,
    output logic [DATA_WIDTH-1:0]  slave_data,
    output logic [NUM_SOURCES-1:0] slave_valids,
    input  logic [NUM_SOURCES-1:0] src_brdcst_subscription
);
    import interconnect_pkg::*;

    localparam int                    PW     = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BRDCST = ADDR_WIDTH'(NUM_SOURCES);

    logic [NUM_SINKS-1:0]   pending_q;
    logic [NUM_SINKS-1:0]   pending_d;
    logic [NUM_SINKS-1:0]   accept;
    logic [DATA_WIDTH-1:0]  hold_data_q [NUM_SINKS];
    logic [ADDR_WIDTH-1:0]  hold_addr_q [NUM_SINKS];
    logic [DATA_WIDTH-1:0]  slave_data_q;
    logic [NUM_SOURCES-1:0] slave_valids_q;
    logic                   grant_valid;
    logic [PW-1:0]          grant_idx;

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_SINKS; i++) begin
            accept[i] = master_valids[i] && (dest_addrs[i] <= BRDCST);
        end
    end

    // A refill on the granting edge keeps the entry pending.
    always_comb begin
        pending_d = pending_q;
        if (grant_valid) begin
            pending_d[grant_idx] = 1'b0;
        end
        pending_d = pending_d | accept;
    end

    rr_arbiter #(
        .N (NUM_SINKS)
    ) u_arb (
        .pclk        (pclk),
        .reset       (reset),
        .req         (pending_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge pclk) begin
        for (int i = 0; i < NUM_SINKS; i++) begin
            if (accept[i]) begin
                hold_data_q[i] <= master_data[i];
                hold_addr_q[i] <= dest_addrs[i];
            end
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            pending_q      <= '0;
            slave_data_q   <= '0;
            slave_valids_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (grant_valid) begin
                slave_data_q <= hold_data_q[grant_idx];
                if (hold_addr_q[grant_idx] == BRDCST) begin
                    slave_valids_q <= src_brdcst_subscription;
                end else begin
                    slave_valids_q <= NUM_SOURCES'(1) << hold_addr_q[grant_idx];
                end
            end else begin
                slave_valids_q <= '0;
            end
        end
    end

    assign slave_data   = slave_data_q;
    assign slave_valids = slave_valids_q;
endmodule

// File: tb/tb_apb_bus_router.sv
// Self-checking bench for apb_bus_router: directed cases plus a randomized soak
// against a per-cycle behavioural model of the routing rules.
module tb_apb_bus_router;
    localparam int NM = 8;
    localparam int NS = 4;

    logic        pclk  = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] master_data [NM];
    logic [5:0]  dest_addrs [NM];
    logic [7:0]  master_valids;
    logic [31:0] slave_data;
    logic [3:0]  slave_valids;
    logic [3:0]  sub;

    int checks   = 0;
    int failures = 0;

    bit          m_pend [NM];
    logic [31:0] m_data [NM];
    int          m_addr [NM];
    int          m_ptr;
    logic [31:0] exp_data;
    logic [3:0]  exp_valids;

    int          seen_a;
    int          seen_b;

    apb_bus_router dut (
        .pclk                    (pclk),
        .reset                   (reset),
        .master_data             (master_data),
        .dest_addrs              (dest_addrs),
        .master_valids           (master_valids),
        .slave_data              (slave_data),
        .slave_valids            (slave_valids),
        .src_brdcst_subscription (sub)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) m_pend[i] = 1'b0;
        m_ptr      = 0;
        exp_data   = '0;
        exp_valids = '0;
    endtask

    // Deliver the first pending entry in round-robin order, then capture new requests.
    task automatic model_edge();
        int g;
        int j;
        g = -1;
        for (int k = 0; k < NM; k++) begin
            j = (m_ptr + k) % NM;
            if (m_pend[j] && g < 0) g = j;
        end
        if (g >= 0) begin
            exp_data   = m_data[g];
            exp_valids = (m_addr[g] == NS) ? sub : 4'(1 << m_addr[g]);
            m_pend[g]  = 1'b0;
            m_ptr      = (g + 1) % NM;
        end else begin
            exp_valids = '0;
        end
        for (int i = 0; i < NM; i++) begin
            if (master_valids[i] && int'(dest_addrs[i]) <= NS) begin
                m_pend[i] = 1'b1;
                m_data[i] = master_data[i];
                m_addr[i] = int'(dest_addrs[i]);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge pclk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        chk({tag, " valids"}, 32'(slave_valids), 32'(exp_valids));
        chk({tag, " data"}, slave_data, exp_data);
        if (slave_valids != 4'b0 && slave_data == 32'hAAAA_0003) seen_a++;
        if (slave_valids != 4'b0 && slave_data == 32'hBBBB_0003) seen_b++;
        master_valids = '0;
    endtask

    task automatic post(input int m, input logic [31:0] d, input logic [5:0] a);
        master_valids[m] = 1'b1;
        master_data[m]   = d;
        dest_addrs[m]    = a;
    endtask

    initial begin
        master_valids = '0;
        sub           = '0;
        seen_a        = 0;
        seen_b        = 0;
        for (int i = 0; i < NM; i++) begin
            master_data[i] = '0;
            dest_addrs[i]  = '0;
            m_data[i]      = '0;
            m_addr[i]      = 0;
        end
        model_reset();

        // Reset held, then released with no traffic
        for (int i = 0; i < 5; i++) step("reset");
        chk("reset valids", 32'(slave_valids), 32'h0);
        chk("reset data", slave_data, 32'h0);
        #2 reset = 1'b1;
        step("idle");
        step("idle");

        // Single unicast: visible only after the second edge
        post(2, 32'hDEAD_BEEF, 6'd3);
        step("uni capture");
        chk("uni early", 32'(slave_valids), 32'h0);
        step("uni deliver");
        chk("uni valids", 32'(slave_valids), 32'h8);
        chk("uni data", slave_data, 32'hDEAD_BEEF);
        step("uni after");
        chk("uni one cycle", 32'(slave_valids), 32'h0);

        // Bring the pointer back to 0 by granting master 7
        post(7, 32'h0000_0777, 6'd0);
        step("wrap");
        step("wrap");

        // Contention from ptr=0
        post(0, 32'h0000_0100, 6'd0);
        post(1, 32'h0000_0101, 6'd1);
        post(5, 32'h0000_0105, 6'd2);
        step("cont capture");
        step("cont d0");
        chk("cont0 valids", 32'(slave_valids), 32'h1);
        chk("cont0 data", slave_data, 32'h100);
        step("cont d1");
        chk("cont1 valids", 32'(slave_valids), 32'h2);
        chk("cont1 data", slave_data, 32'h101);
        step("cont d2");
        chk("cont2 valids", 32'(slave_valids), 32'h4);
        chk("cont2 data", slave_data, 32'h105);
        step("cont idle");
        // ptr should be 6: master 6 beats master 5
        post(5, 32'h0000_0205, 6'd1);
        post(6, 32'h0000_0206, 6'd2);
        step("ptr capture");
        step("ptr first");
        chk("ptr6 first data", slave_data, 32'h206);
        step("ptr second");
        chk("ptr6 second data", slave_data, 32'h205);

        // Broadcast, subscription sampled at the grant edge
        sub = 4'b0101;
        post(4, 32'hB0AD_0001, 6'd4);
        step("bc capture");
        sub = 4'b1010;
        step("bc deliver");
        chk("bc valids", 32'(slave_valids), 32'hA);
        chk("bc data", slave_data, 32'hB0AD_0001);
        step("bc after");
        sub = 4'b0000;
        post(4, 32'hB0AD_0002, 6'd4);
        step("bc0 capture");
        step("bc0 deliver");
        chk("bc0 valids", 32'(slave_valids), 32'h0);
        chk("bc0 data", slave_data, 32'hB0AD_0002);
        for (int i = 0; i < 3; i++) step("bc0 idle");

        // Invalid addresses are dropped
        post(1, 32'h1111_1111, 6'd5);
        step("inv capture");
        post(2, 32'h2222_2222, 6'd63);
        for (int i = 0; i < 5; i++) begin
            step("inv idle");
            chk("inv none", 32'(slave_valids), 32'h0);
        end

        // Overwrite: master 3 refilled while queued behind the others
        for (int m = 0; m < NM; m++) begin
            if (m != 3) post(m, 32'h0000_5000 + 32'(m), 6'(m % 4));
        end
        post(3, 32'hAAAA_0003, 6'd3);
        step("ow capture");
        post(3, 32'hBBBB_0003, 6'd3);
        for (int i = 0; i < 12; i++) step("ow drain");
        chk("ow old dropped", 32'(seen_a), 32'd0);
        chk("ow new once", 32'(seen_b), 32'd1);

        // Randomized soak
        for (int c = 0; c < 400; c++) begin
            sub = 4'($urandom);
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) post(m, $urandom, 6'($urandom_range(5, 63)));
                    else                           post(m, $urandom, 6'($urandom_range(0, 4)));
                end
            end
            step("soak");
        end
        for (int i = 0; i < NM + 2; i++) step("soak drain");

        // Asynchronous reset mid-operation discards pending work
        post(0, 32'hC0DE_0000, 6'd0);
        post(1, 32'hC0DE_0001, 6'd1);
        post(2, 32'hC0DE_0002, 6'd2);
        step("mid capture");
        step("mid deliver");
        #2 reset = 1'b0;
        #1;
        chk("async valids", 32'(slave_valids), 32'h0);
        chk("async data", slave_data, 32'h0);
        step("mid reset");
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) step("post reset idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
